// File: rtl/ldtu_ififo_gsel.sv
// ldtu_ififo_gsel: lookahead FIFO with g1/g10 gain selection feeding the LiTe-DTU encoder.
// Samples are delayed by LOOK valid samples so that a saturation seen at the input can
// switch the emitted gain to g1 for the LOOK samples before it and WINDOW_len samples after.
// Optional feature: define LDTU_GSEL_SATCNT_EN to enable the saturation event counter on
// sat_cnt; when it is undefined, sat_cnt is tied to zero.
module ldtu_ififo_gsel #(
    parameter int unsigned NBITS = 12,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIN_W = 5
) (
    input  logic                     CLK_,
    input  logic                     reset_,
    input  logic                     in_valid,
    input  logic [NBITS-1:0]         DATA_gain_01,
    input  logic [NBITS-1:0]         DATA_gain_10,
    input  logic [NBITS-1:0]         SATURATION_value,
    input  logic [1:0]               shift_gain_10,
    input  logic [1:0]               GAIN_SEL_MODE,
    input  logic [WIN_W-1:0]         WINDOW_len,
    input  logic [$clog2(DEPTH)-1:0] LOOKAHEAD,
    output logic [NBITS:0]           DATA_to_enc,
    output logic                     out_valid,
    output logic                     baseline_flag,
    output logic [15:0]              sat_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StFill, StRunG10, StRunG1} state_e;

    state_e           state_q, state_d;
    logic [NBITS-1:0] mem_g1  [DEPTH];
    logic [NBITS-1:0] mem_g10 [DEPTH];
    logic [AW-1:0]    wptr, rptr, fill, look;
    logic [NBITS-1:0] sat_val;
    // Saturation window is split in two phases: la_cnt covers the samples still in the
    // lookahead span (older than the saturating one), hold_cnt the WINDOW_len samples after.
    logic [AW-1:0]    la_cnt, la_d;
    logic [WIN_W-1:0] hold_cnt, hold_d;

    logic [NBITS-1:0] g10_shift;
    logic             auto_mode, sat_in, running, emit, pending, sel_g1;
    logic [NBITS:0]   rd_word;
    logic [AW-1:0]    fill_inc;

    assign g10_shift = DATA_gain_10 >> shift_gain_10;
    assign auto_mode = ~GAIN_SEL_MODE[1];
    assign sat_in    = in_valid & auto_mode & (g10_shift >= sat_val);
    assign running   = (state_q != StFill);
    assign emit      = in_valid & running;
    assign pending   = (la_cnt != '0) | (hold_cnt != '0);
    assign sel_g1    = auto_mode ? (sat_in | pending) : GAIN_SEL_MODE[0];
    assign rd_word   = sel_g1 ? {1'b1, mem_g1[rptr]} : {1'b0, mem_g10[rptr]};
    assign fill_inc  = fill + 1'b1;

    // Window counters: retrigger on saturation, count down on valid samples, clear when forced
    always_comb begin
        la_d   = la_cnt;
        hold_d = hold_cnt;
        if (!auto_mode) begin
            la_d   = '0;
            hold_d = '0;
        end else if (sat_in) begin
            la_d   = look;
            hold_d = WINDOW_len;
        end else if (in_valid) begin
            // The lookahead part also drains during fill so a saturation inside the first
            // LOOK samples covers exactly the samples that precede it.
            if (la_cnt != '0) begin
                la_d = la_cnt - 1'b1;
            end else if (running && (hold_cnt != '0)) begin
                hold_d = hold_cnt - 1'b1;
            end
        end
    end

    // Next-state: FILL until LOOK samples are buffered, then track the last emitted gain
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill: begin
                if (in_valid && (fill_inc == look)) begin
                    state_d = ((la_d != '0) || (hold_d != '0)) ? StRunG1 : StRunG10;
                end
            end
            StRunG10, StRunG1: begin
                if (emit) begin
                    state_d = sel_g1 ? StRunG1 : StRunG10;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK_) begin
        if (!reset_) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointers, fill level, threshold, window counters and the latched lookahead
    always_ff @(posedge CLK_) begin
        if (!reset_) begin
            wptr     <= '0;
            rptr     <= '0;
            fill     <= '0;
            look     <= (LOOKAHEAD == '0) ? AW'(1) : LOOKAHEAD;
            sat_val  <= '1;
            la_cnt   <= '0;
            hold_cnt <= '0;
        end else begin
            sat_val  <= SATURATION_value >> shift_gain_10;
            la_cnt   <= la_d;
            hold_cnt <= hold_d;
            if (in_valid) begin
                wptr <= wptr + 1'b1;
                if (running) begin
                    rptr <= rptr + 1'b1;
                end else begin
                    fill <= fill_inc;
                end
            end
        end
    end

    // Sample buffers: both gains written together at the shared write pointer
    always_ff @(posedge CLK_) begin
        if (!reset_) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_g1[i]  <= '0;
                mem_g10[i] <= '0;
            end
        end else if (in_valid) begin
            mem_g1[wptr]  <= DATA_gain_01;
            mem_g10[wptr] <= g10_shift;
        end
    end

    // Output register: updated only when a sample is emitted, otherwise held
    always_ff @(posedge CLK_) begin
        if (!reset_) begin
            DATA_to_enc   <= '0;
            out_valid     <= 1'b0;
            baseline_flag <= 1'b1;
        end else begin
            out_valid <= emit;
            if (emit) begin
                DATA_to_enc <= rd_word;
                // In automatic mode a g1 sample is never baseline (gain bit included).
                baseline_flag <= auto_mode ? (rd_word[NBITS:6] == '0)
                                           : (rd_word[NBITS-1:6] == '0);
            end
        end
    end

`ifdef LDTU_GSEL_SATCNT_EN
    logic [15:0] sat_cnt_q;
    logic        enter_g1;

    // A g10->g1 change of the emitted gain; retriggers stay in RUN_G1 and are not counted
    assign enter_g1 = (state_d == StRunG1) && (state_q != StRunG1);

    // Saturation event counter, sticks at all ones
    always_ff @(posedge CLK_) begin
        if (!reset_) begin
            sat_cnt_q <= '0;
        end else if (enter_g1 && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_cnt = sat_cnt_q;
`else
    assign sat_cnt = 16'h0000;
`endif

endmodule

// File: doc/ldtu_ififo_gsel.md
LDTU_IFIFO_GSEL -- requirements
Module: ldtu_ififo_gsel

Interface
REQ-001 The parameter NBITS SHALL default to 12 and SHALL set the sample width.
REQ-002 The parameter DEPTH SHALL default to 16, SHALL be a power of 2 of at least 8, and SHALL set the number of FIFO entries per gain.
REQ-003 The parameter WIN_W SHALL default to 5 and SHALL set the width of the window-length input.
REQ-004 Port CLK_ SHALL be an input of width 1 and SHALL be the single LiTe-DTU clock; all logic SHALL be on posedge CLK_.
REQ-005 Port reset_ SHALL be an input of width 1 and SHALL be a synchronous, active-low reset (0 = reset, 1 = active).
REQ-006 Port in_valid SHALL be an input of width 1 that qualifies one new sample pair.
REQ-007 Ports DATA_gain_01 and DATA_gain_10 SHALL be inputs of width NBITS carrying baseline-subtracted samples.
REQ-008 Port SATURATION_value SHALL be an input of width NBITS giving the saturation threshold.
REQ-009 Port shift_gain_10 SHALL be an input of width 2 giving the right-shift applied to both the g10 samples and the threshold.
REQ-010 Port GAIN_SEL_MODE SHALL be an input of width 2: 0x = automatic, 10 = forced g10, 11 = forced g1.
REQ-011 Port WINDOW_len SHALL be an input of width WIN_W giving the number of post-saturation samples held on g1.
REQ-012 Port LOOKAHEAD SHALL be an input of width log2(DEPTH) giving the delay, in valid samples, between input and output.
REQ-013 Port DATA_to_enc SHALL be an output of width NBITS+1 carrying {gain_bit, sample}, with gain_bit = 1 meaning g1.
REQ-014 Port out_valid SHALL be an output of width 1 that qualifies DATA_to_enc.
REQ-015 Port baseline_flag SHALL be an output of width 1 that is 1 when the output sample is baseline.
REQ-016 Port sat_cnt SHALL be an output of width 16 carrying the saturation event count.

Function
REQ-017 The block SHALL hold two circular buffers of DEPTH entries (g1 and g10) sharing one write pointer and one read pointer, each advanced only on in_valid=1 and wrapping modulo DEPTH.
REQ-018 The g10 entry SHALL be written as DATA_gain_10 >> shift_gain_10.
REQ-019 The block SHALL keep a registered threshold SATval = SATURATION_value >> shift_gain_10.
REQ-020 LOOK SHALL be LOOKAHEAD latched during reset; a value of 0 SHALL be treated as 1, and LOOK SHALL remain constant while reset_=1.
REQ-021 The block SHALL implement an FSM with states FILL, RUN_G10 and RUN_G1, entering FILL on reset.
REQ-022 In FILL, each in_valid SHALL write one sample and increment fill; when fill==LOOK the FSM SHALL move to RUN_G10, or to RUN_G1 if hold_cnt!=0; no output SHALL be produced in FILL.
REQ-023 In a RUN state, each in_valid SHALL write the new sample and read the sample written LOOK valid-samples earlier; the read sample SHALL appear on DATA_to_enc at the next edge with out_valid=1.
REQ-024 out_valid SHALL be 0 in every other cycle.
REQ-025 sat_in SHALL be 1 when in_valid=1, the mode is automatic, and (DATA_gain_10 >> shift_gain_10) >= SATval.
REQ-026 On sat_in=1, in any state, hold_cnt SHALL load WINDOW_len (retrigger); otherwise, on in_valid in a RUN state with hold_cnt!=0, it SHALL decrement by 1.
REQ-027 Output gain selection SHALL be g1 when sat_in=1 or hold_cnt!=0, and g10 otherwise; the FSM SHALL be in RUN_G1 when the last emitted sample was g1, and in RUN_G10 otherwise.
REQ-028 The effective g1 window SHALL therefore be LOOK samples before the saturating sample through WINDOW_len samples after it.
REQ-029 Forced g10 mode SHALL output {0, g10 sample}, and forced g1 mode SHALL output {1, g1 sample}.
REQ-030 Entering a forced mode SHALL clear hold_cnt the same cycle; pointers and fill SHALL NOT be disturbed by a mode change.
REQ-031 With WINDOW_len=0, only the samples in the lookahead span plus the saturating sample SHALL be g1.
REQ-032 baseline_flag SHALL be registered with DATA_to_enc: in automatic mode it SHALL be 1 when DATA_to_enc[NBITS:6]==0, and in forced modes when DATA_to_enc[NBITS-1:6]==0.
REQ-033 When in_valid=0, no pointer, fill, hold_cnt or FSM state SHALL change, and the output registers SHALL hold their value with out_valid=0.

Reset
REQ-034 While reset_=0 at a clock edge, the block SHALL clear both pointers, fill and hold_cnt, set the FSM to FILL, set SATval to all ones, and latch LOOK.
REQ-035 The output reset values SHALL be DATA_to_enc=0, out_valid=0, baseline_flag=1 and sat_cnt=0.
REQ-036 Buffer contents SHALL be cleared to 0 on reset.
REQ-037 A reset asserted mid-stream SHALL discard all buffered samples, and the first output after release SHALL come only after LOOK new valid samples.

Configuration
REQ-038 With the macro LDTU_GSEL_SATCNT_EN defined, sat_cnt SHALL increment by 1 on each rising edge of the g1 selection (a g10-to-g1 transition of the emitted gain, with a retrigger inside the window not counted) and SHALL saturate at 16'hFFFF.
REQ-039 Without LDTU_GSEL_SATCNT_EN, sat_cnt SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-040 Fill/latency: LOOK=3, auto mode, ramp g10=1,2,3,... continuously valid -> the first out_valid occurs on the edge after the 4th in_valid, with DATA_to_enc=13'h0001 followed by 2, 3, ...
REQ-041 Saturation window: SATURATION_value=12'hFF0, shift=0, LOOK=3, WINDOW_len=4, a single g10 sample 12'hFFF at index 10 -> outputs for samples 7..14 carry gain_bit=1 with g1 data, and all other samples are g10.
REQ-042 Retrigger and wrap: DEPTH=16, saturating samples at indices 20 and 22 with WINDOW_len=4 -> one continuous g1 span covering 17..26, and sat_cnt=1 with the macro defined.
REQ-043 Gaps: with in_valid toggling 1/0 -> the output sequence is identical to the continuous case, out_valid is 0 in gap cycles, and hold_cnt does not decrement in gaps.
REQ-044 Forced mode and baseline: mode 11 with g1=12'h03F -> DATA_to_enc=13'h103F and baseline_flag=1; mode 00 with the same value selected as g1 -> baseline_flag=0.
REQ-045 Reset mid-stream: reset_=0 for one cycle during a g1 window -> outputs return to their reset values, hold_cnt is cleared, and the next output follows a fresh fill of LOOK samples with gain g10.
